wb_host_initiator: RTL and testbench

Single-outstanding Wishbone classic initiator. It converts a valid/ready command stream into Wishbone read and write cycles toward wishbone responders such as the logic-analyzer register block. It returns read data or a timeout error on a valid/ready response stream. It is the host-side bus engine used by the management-side sequencers and by the block-level benches driving responders.

---
 rtl/wb_host_pkg.sv | 16 +
 rtl/wb_host_timer.sv | 44 ++++
 rtl/wb_host_initiator.sv | 173 +++++++++++++++++
 tb/tb_wb_host_initiator.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host initiator.
// Imported by the timer and the top-level engine.
package wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic RSP_ERR_NONE    = 1'b0;
    localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/wb_host_timer.sv
// Saturating bus-cycle timer for the Wishbone host initiator.
// expired_o means the current wait cycle is the TIMEOUT-th one.
module wb_host_timer
    import wb_host_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count up and stick at TIMEOUT
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // TIMEOUT-1 waits already elapsed: this edge would make it TIMEOUT
    assign expired_o = (count_q >= LAST);

endmodule

// File: rtl/wb_host_initiator.sv
// Single-outstanding Wishbone classic initiator.
// Command stream in, one bus cycle, response stream out.
module wb_host_initiator
    import wb_host_pkg::*;
#(
    parameter int unsigned ADR_W   = 32,
    parameter int unsigned DAT_W   = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [ADR_W-1:0]   cmd_adr_i,
    input  logic [DAT_W-1:0]   cmd_dat_i,
    input  logic [DAT_W/8-1:0] cmd_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic               rsp_err_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [ADR_W-1:0]   wb_adr_o,
    output logic [DAT_W-1:0]   wb_dat_o,
    output logic [DAT_W/8-1:0] wb_sel_o,
    input  logic               wb_ack_i,
    input  logic [DAT_W-1:0]   wb_dat_i
);

    localparam int unsigned SEL_W = DAT_W / 8;

    state_e state_q, state_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

    logic accept;
    logic bus_ack;
    logic bus_wait;
    logic expired;
    logic bus_abort;

    assign accept    = (state_q == IDLE) && cmd_valid_i;
    assign bus_ack   = (state_q == BUS) && wb_ack_i;
    assign bus_wait  = (state_q == BUS) && !wb_ack_i;
    assign bus_abort = bus_wait && expired;

    wb_host_timer #(
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .clr_i     (accept),
        .en_i      (bus_wait),
        .expired_o (expired)
    );

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: ack takes priority over an expiring timer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = BUS;
            BUS:  if (bus_ack || bus_abort) state_d = RESP;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs
    always_comb begin
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    sel_d       = cmd_sel_i;
                end
            end
            BUS: begin
                if (bus_ack) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RSP_ERR_NONE;
                    rsp_dat_d   = we_q ? '0 : wb_dat_i;
                end else if (bus_abort) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RSP_ERR_TIMEOUT;
                    rsp_dat_d   = '0;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    we_d        = 1'b0;
                end
            end
            default: begin
                cmd_ready_d = 1'b1;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Output registers; reset drops cyc/stb immediately
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_host_initiator.sv
// Bench for wb_host_initiator: register-file responder, table vectors,
// random transactions against a transaction-level model, corner sequences.
module tb_wb_host_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    always #5 clk = ~clk;

    wb_host_initiator #(
        .ADR_W(32), .DAT_W(32), .TIMEOUT(TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i),
        .wb_dat_i   (wb_dat_i)
    );

    // Responder: 16-word register file, ack after ack_dly wait cycles
    logic [31:0] rmem [16] = '{default: 32'h0};
    int ack_dly = 0;
    bit ack_en = 1'b1;
    bit stray_ack = 1'b0;
    int bcnt = 0;

    always @(posedge clk) begin
        if (!wb_cyc_o) bcnt <= 0;
        else bcnt <= bcnt + 1;
        if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) begin
            for (int b = 0; b < 4; b++)
                if (wb_sel_o[b])
                    rmem[wb_adr_o[5:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
        end
    end

    assign wb_ack_i = stray_ack | (wb_cyc_o && ack_en && (bcnt == ack_dly));
    assign wb_dat_i = rmem[wb_adr_o[5:2]];

    // Transaction-level reference model
    logic [31:0] mmem [16] = '{default: 32'h0};

    task automatic model_txn(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel,
                             input bit en, input int dly,
                             output logic err, output logic [31:0] rdat,
                             output int ncyc);
        bit timed_out;
        int i;
        timed_out = !en || (dly >= TO);
        i = int'(adr[5:2]);
        ncyc = timed_out ? TO : dly + 1;
        err = timed_out;
        rdat = 32'h0;
        if (!timed_out && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) mmem[i][8*b +: 8] = dat[8*b +: 8];
        end
        if (!timed_out && !we) rdat = mmem[i];
    endtask

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // One command through handshake, bus, optional backpressure, release
    task automatic run_txn(input string nm, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit en,
                           input int dly, input int bp,
                           input logic exp_err, input logic [31:0] exp_dat,
                           input int exp_cyc);
        int n;
        int cyc_cnt;
        bit stable;
        logic [31:0] hd;
        logic he;
        ack_en = en;
        ack_dly = dly;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".ready"}, cmd_ready_o, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom;
        cmd_sel = ~sel;
        n = 0; cyc_cnt = 0; stable = 1'b1;
        while (!rsp_valid_o && n < 100) begin
            if (wb_cyc_o) begin
                cyc_cnt++;
                if (wb_stb_o !== 1'b1 || wb_we_o !== we ||
                    wb_adr_o !== adr || wb_dat_o !== dat ||
                    wb_sel_o !== sel || cmd_ready_o !== 1'b0)
                    stable = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk({nm, ".rsp_valid"}, rsp_valid_o, 1);
        chk({nm, ".latency"}, n + 1, exp_cyc + 1);
        chk({nm, ".cyc_cycles"}, cyc_cnt, exp_cyc);
        chk({nm, ".bus_stable"}, stable, 1);
        chk({nm, ".cyc_drop"}, {wb_cyc_o, wb_stb_o}, 0);
        chk({nm, ".err"}, rsp_err_o, exp_err);
        chk({nm, ".dat"}, rsp_dat_o, exp_dat);
        hd = rsp_dat_o; he = rsp_err_o; stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            stray_ack = (i % 2) == 1;
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== hd ||
                rsp_err_o !== he || cmd_ready_o !== 1'b0 ||
                wb_cyc_o !== 1'b0)
                stable = 1'b0;
        end
        stray_ack = 1'b0;
        if (bp > 0) chk({nm, ".bp_hold"}, stable, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, ".release"}, {rsp_valid_o, cmd_ready_o, wb_we_o}, 3'b010);
        chk({nm, ".wb_keep"}, {wb_dat_o, wb_sel_o}, {dat, sel});
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          en;
        int          dly;
        int          bp;
        logic        err;
        logic [31:0] rdat;
        int          ncyc;
    } vec_t;

    vec_t tbl [11];

    typedef struct {
        logic        err;
        logic [31:0] dat;
    } exp_t;

    exp_t q_exp [$];

    logic        m_err;
    logic [31:0] m_dat;
    int          m_cyc;
    logic        b_we  [8];
    logic [31:0] b_adr [8];
    logic [31:0] b_dat [8];
    int          bidx, got, rises;
    bit          acc, prev_cyc, overlap, quiet;
    exp_t        e;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF, 1, 0, 0,
                    1'b0, 32'h0, 1};
        tbl[1]  = '{1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 0, 0,
                    1'b0, 32'hA5A5_1234, 1};
        tbl[2]  = '{1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 0, 0,
                    1'b1, 32'h0, 16};
        tbl[3]  = '{1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 1, 10,
                    1'b0, 32'hA5A5_1234, 2};
        tbl[4]  = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'h3, 1, 2, 0,
                    1'b0, 32'h0, 3};
        tbl[5]  = '{1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 15, 0,
                    1'b0, 32'h0000_BEEF, 16};
        tbl[6]  = '{1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 16, 0,
                    1'b1, 32'h0, 16};
        tbl[7]  = '{1'b1, 32'h3000_0004, 32'h1111_2222, 4'hF, 1, 16, 0,
                    1'b1, 32'h0, 16};
        tbl[8]  = '{1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 3, 2,
                    1'b0, 32'h0000_BEEF, 4};
        tbl[9]  = '{1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'hC, 1, 0, 0,
                    1'b0, 32'h0, 1};
        tbl[10] = '{1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 0, 0,
                    1'b0, 32'hCAFE_0000, 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {cmd_ready_o, rsp_valid_o, rsp_err_o, wb_cyc_o, wb_stb_o,
             wb_we_o},
            6'b100000);
        chk("reset_data", {rsp_dat_o, wb_adr_o, wb_dat_o, wb_sel_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            model_txn(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel,
                      tbl[i].en, tbl[i].dly, m_err, m_dat, m_cyc);
            run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr,
                    tbl[i].dat, tbl[i].sel, tbl[i].en, tbl[i].dly,
                    tbl[i].bp, tbl[i].err, tbl[i].rdat, tbl[i].ncyc);
        end

        // Random transactions against the model
        for (int i = 0; i < 30; i++) begin
            logic        r_we;
            logic [31:0] r_adr, r_dat;
            logic [3:0]  r_sel;
            bit          r_en;
            int          r_dly, r_bp;
            r_we  = 1'($urandom_range(0, 1));
            r_adr = 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2);
            r_dat = $urandom;
            r_sel = 4'($urandom_range(1, 15));
            r_en  = $urandom_range(0, 7) != 0;
            r_dly = $urandom_range(0, 18);
            r_bp  = $urandom_range(0, 3);
            model_txn(r_we, r_adr, r_dat, r_sel, r_en, r_dly,
                      m_err, m_dat, m_cyc);
            run_txn($sformatf("rnd%0d", i), r_we, r_adr, r_dat, r_sel,
                    r_en, r_dly, r_bp, m_err, m_dat, m_cyc);
        end

        // Reset in the middle of a bus cycle
        ack_en = 1'b0;
        cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_cyc", wb_cyc_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop",
            {wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 ||
                wb_cyc_o !== 1'b0)
                quiet = 1'b0;
        end
        chk("rst_no_rsp", quiet, 1);
        model_txn(1'b1, 32'h3000_0030, 32'h5A5A_0F0F, 4'hF, 1, 1,
                  m_err, m_dat, m_cyc);
        run_txn("post_rst_wr", 1'b1, 32'h3000_0030, 32'h5A5A_0F0F, 4'hF,
                1, 1, 0, m_err, m_dat, m_cyc);
        model_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1, 0,
                  m_err, m_dat, m_cyc);
        run_txn("post_rst_rd", 1'b0, 32'h3000_0030, 32'h0, 4'hF,
                1, 0, 0, m_err, m_dat, m_cyc);

        // Back-to-back: valid held high, rsp_ready tied high
        for (int i = 0; i < 4; i++) begin
            b_we[i] = 1'b1;
            b_adr[i] = 32'h3000_0010 + 32'(4 * i);
            b_dat[i] = $urandom;
            b_we[i+4] = 1'b0;
            b_adr[i+4] = 32'h3000_0010 + 32'(4 * i);
            b_dat[i+4] = 32'h0;
        end
        q_exp.delete();
        ack_en = 1'b1; ack_dly = 0;
        bidx = 0; got = 0; rises = 0; prev_cyc = 1'b0; overlap = 1'b0;
        cmd_we = b_we[0]; cmd_adr = b_adr[0]; cmd_dat = b_dat[0];
        cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 200 && got < 8; c++) begin
            acc = cmd_valid && cmd_ready_o;
            if (cmd_ready_o && rsp_valid_o) overlap = 1'b1;
            if (wb_cyc_o && !prev_cyc) rises++;
            prev_cyc = wb_cyc_o;
            if (rsp_valid_o) begin
                if (q_exp.size() == 0) begin
                    chk("b2b_unexpected_rsp", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    chk($sformatf("b2b%0d.err", got), rsp_err_o, e.err);
                    chk($sformatf("b2b%0d.dat", got), rsp_dat_o, e.dat);
                end
                got++;
            end
            if (acc) begin
                model_txn(cmd_we, cmd_adr, cmd_dat, cmd_sel, 1, 0,
                          m_err, m_dat, m_cyc);
                e.err = m_err;
                e.dat = m_dat;
                q_exp.push_back(e);
            end
            @(negedge clk);
            if (acc) begin
                bidx++;
                if (bidx < 8) begin
                    cmd_we = b_we[bidx]; cmd_adr = b_adr[bidx];
                    cmd_dat = b_dat[bidx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("b2b_count", got, 8);
        chk("b2b_cyc_gaps", rises, 8);
        chk("b2b_no_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
